// File: rtl/ram_copy_engine.sv
// Block copy engine: moves len words from src to dst in a single-port RAM,
// spending one READ cycle and one WRITE cycle per word, forward order only.
module ram_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_read
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  // State, pointers, word counter and data buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic with Moore outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    count_d   = count_q;
    buf_d     = buf_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    ram_ld    = 1'b0;
    ram_str   = 1'b0;
    ram_addr  = '0;
    ram_write = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          if (len != '0) begin
            src_d   = src;
            dst_d   = dst;
            len_d   = len;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        ram_ld   = 1'b1;
        ram_addr = src_q;
        buf_d    = ram_read;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        ram_str  = 1'b1;
        ram_addr = dst_q;
        // Pointers wrap naturally at 2^ADDR_W.
        src_d    = src_q + ADDR_W'(1);
        dst_d    = dst_q + ADDR_W'(1);
        count_d  = count_q + (ADDR_W+1)'(1);
        if (count_d == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign count = count_q;

endmodule
